// File: rtl/arr_bank_arb.sv
// Single synchronous RAM shared by NPORTS round-robin datapath ports and an overriding host port,
// with optional post-reset zero-fill, address range checking and per-port read-valid tagging.
module arr_bank_arb #(
    parameter int DATA_W        = 64,
    parameter int DEPTH         = 2,
    parameter int ADDR_W        = 1,
    parameter int NPORTS        = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ctrl_sel,
    input  logic                     ctrl_we,
    input  logic [ADDR_W-1:0]        ctrl_addr,
    input  logic [DATA_W-1:0]        ctrl_wdata,
    output logic [DATA_W-1:0]        ctrl_rdata,
    output logic                     ctrl_rvalid,
    input  logic [NPORTS-1:0]        core_req,
    input  logic [NPORTS-1:0]        core_we,
    input  logic [NPORTS*ADDR_W-1:0] core_addr,
    input  logic [NPORTS*DATA_W-1:0] core_wdata,
    output logic [NPORTS-1:0]        core_gnt,
    output logic [DATA_W-1:0]        core_rdata,
    output logic [NPORTS-1:0]        core_rvalid,
    output logic                     init_busy,
    output logic                     addr_err
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  NPORTS_V = (PTR_W+1)'(NPORTS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   ctrl_rdata_q, core_rdata_q;
    logic                ctrl_rvalid_q, addr_err_q;
    logic [NPORTS-1:0]   core_rvalid_q;

    logic                acc_en, acc_we, acc_host, found, in_range;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata, rd_word;
    logic [NPORTS-1:0]   gnt;
    logic [PTR_W-1:0]    idx;
    logic [PTR_W:0]      sum, nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        gnt       = '0;
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_host  = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        found     = 1'b0;
        idx       = '0;
        sum       = '0;
        nxt       = '0;
        if (state_q == ST_INIT) begin
            acc_en   = 1'b1;
            acc_we   = 1'b1;
            acc_addr = cnt_q;
            cnt_d    = cnt_q + 1'b1;
            if ({1'b0, cnt_q} == DEPTH_V - 1'b1) begin
                state_d = ST_RUN;
            end
        end else if (ctrl_sel) begin
            acc_en    = 1'b1;
            acc_host  = 1'b1;
            acc_we    = ctrl_we;
            acc_addr  = ctrl_addr;
            acc_wdata = ctrl_wdata;
        end else begin
            // Scan ports starting at the pointer, wrapping modulo NPORTS.
            for (int unsigned k = 0; k < NPORTS; k++) begin
                sum = {1'b0, rr_q} + (PTR_W+1)'(k);
                if (sum >= NPORTS_V) begin
                    sum = sum - NPORTS_V;
                end
                if (!found && core_req[sum[PTR_W-1:0]]) begin
                    found = 1'b1;
                    idx   = sum[PTR_W-1:0];
                end
            end
            if (found) begin
                gnt[idx]  = 1'b1;
                acc_en    = 1'b1;
                acc_we    = core_we[idx];
                acc_addr  = core_addr[idx*ADDR_W +: ADDR_W];
                acc_wdata = core_wdata[idx*DATA_W +: DATA_W];
                nxt       = {1'b0, idx} + 1'b1;
                rr_d      = (nxt >= NPORTS_V) ? '0 : nxt[PTR_W-1:0];
            end
        end
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_V);
    assign rd_word  = in_range ? mem[acc_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst_n && acc_en && acc_we && in_range) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            cnt_q         <= '0;
            rr_q          <= '0;
            core_rvalid_q <= '0;
            ctrl_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            ctrl_rdata_q  <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            core_rvalid_q <= '0;
            ctrl_rvalid_q <= 1'b0;
            if (acc_en && !acc_we) begin
                if (acc_host) begin
                    ctrl_rvalid_q <= 1'b1;
                    ctrl_rdata_q  <= rd_word;
                end else begin
                    core_rvalid_q <= gnt;
                    core_rdata_q  <= rd_word;
                end
            end
            if (acc_en && !in_range) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign core_gnt    = gnt;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign ctrl_rvalid = ctrl_rvalid_q;
    assign ctrl_rdata  = ctrl_rdata_q;
    assign init_busy   = (state_q == ST_INIT);
    assign addr_err    = addr_err_q;

endmodule
